// File: rtl/pipeline_id_regfile_sb_if.sv
// rtl/pipeline_id_regfile_sb_if.sv - decode/writeback bundle for the ID register file
interface pipeline_id_regfile_sb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  // read ports
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD-1:0]      rs_used;
  logic [NRD*XLEN-1:0] rs_data;

  // issue handshake from decode
  logic                issue_valid;
  logic                issue_wr_en;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic                issue_ready;
  logic                issue_fire;

  // writeback / release from WB
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                wb_clr;

  // scoreboard view
  logic [NREGS-1:0]    busy_vec;

  // decode/WB side drives requests and observes results
  modport master (
    output rs_addr, rs_used, issue_valid, issue_wr_en, issue_rd, flush,
           wb_en, wb_addr, wb_data, wb_clr,
    input  rs_data, issue_ready, issue_fire, busy_vec
  );

  // register file side
  modport slave (
    input  rs_addr, rs_used, issue_valid, issue_wr_en, issue_rd, flush,
           wb_en, wb_addr, wb_data, wb_clr,
    output rs_data, issue_ready, issue_fire, busy_vec
  );
endinterface

// File: rtl/pipeline_id_regfile_sb.sv
// rtl/pipeline_id_regfile_sb.sv - decode register file with write-through bypass and busy scoreboard
module pipeline_id_regfile_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  pipeline_id_regfile_sb_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NREGS-1:0]    busy_q;
  logic [NREGS-1:0]    busy_d;

  logic [NRD-1:0]      raw;
  logic [NRD*XLEN-1:0] rs_data_c;
  logic                wb_release;
  logic                waw;
  logic                issue_ready_c;
  logic                issue_fire_c;

  // Either writeback flavour frees the busy bit; wb_en wins when both are
  // (illegally) high, which makes no difference to the release itself.
  assign wb_release = (bus.wb_en || bus.wb_clr) && (bus.wb_addr != '0);

  // Per read port: zero for x0, bypass from WB on an address match, else
  // the stored value. A port stalls only when it is used, its source is
  // busy, and WB is not supplying the data this very cycle (wb_clr brings
  // no data, so it does not unblock a reader).
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit_wb;

    assign addr   = bus.rs_addr[k*AW +: AW];
    assign hit_wb = bus.wb_en && (bus.wb_addr == addr);

    assign rs_data_c[k*XLEN +: XLEN] = (addr == '0) ? '0
                                     : hit_wb       ? bus.wb_data
                                     :                regs_q[addr];

    assign raw[k] = bus.rs_used[k] && (addr != '0) && busy_q[addr] && !hit_wb;
  end

  // A destination that is still owned by an older producer blocks issue,
  // unless that producer is released in the same cycle.
  assign waw = bus.issue_wr_en && (bus.issue_rd != '0) && busy_q[bus.issue_rd]
               && !((bus.wb_en || bus.wb_clr) && (bus.wb_addr == bus.issue_rd));

  // issue_ready ignores issue_valid so decode may use it combinationally.
  assign issue_ready_c = !(|raw) && !waw;
  assign issue_fire_c  = bus.issue_valid && issue_ready_c && !bus.flush;

  assign bus.rs_data     = rs_data_c;
  assign bus.issue_ready = issue_ready_c;
  assign bus.issue_fire  = issue_fire_c;
  assign bus.busy_vec    = busy_q;

  // Next register contents: writeback stores, x0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en && (bus.wb_addr != '0)) begin
      regs_d[bus.wb_addr] = bus.wb_data;
    end
  end

  // Next scoreboard: release first, then a new producer re-claims the bit
  // so that set beats clear on the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_release) begin
      busy_d[bus.wb_addr] = 1'b0;
    end
    if (issue_fire_c && bus.issue_wr_en && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State update; reset clears data and scoreboard and beats any write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      regs_q <= regs_d;
    end
  end

  // A writeback or clear must target a register that has an owner.
  a_wb_to_busy : assert property (@(posedge clk) disable iff (!reset)
    ((bus.wb_en || bus.wb_clr) && (bus.wb_addr != '0)) |-> busy_q[bus.wb_addr]);

  // A producer may only claim a busy destination if it is freed this cycle.
  a_fire_to_busy : assert property (@(posedge clk) disable iff (!reset)
    (issue_fire_c && bus.issue_wr_en && (bus.issue_rd != '0) && busy_q[bus.issue_rd])
      |-> ((bus.wb_en || bus.wb_clr) && (bus.wb_addr == bus.issue_rd)));

endmodule

// File: tb/tb_pipeline_id_regfile_sb.sv
// tb/tb_pipeline_id_regfile_sb.sv - randomized and directed bench for the ID register file
module tb_pipeline_id_regfile_sb;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk;
  logic reset;
  logic check_en;
  int   n_checks;
  int   n_fail;

  logic [63:0] m_reg [NREGS];
  logic [31:0] m_busy;

  pipeline_id_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  pipeline_id_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a read port must return under the current inputs.
  function automatic logic [63:0] exp_rd(input int k);
    logic [AW-1:0] a;
    a = bus.rs_addr[k*AW +: AW];
    if (a == 0) return 64'd0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_reg[a];
  endfunction

  // Reference: may the decode-slot instruction advance?
  function automatic bit exp_ready();
    logic [AW-1:0] a;
    bit stall;
    stall = 0;
    for (int k = 0; k < NRD; k++) begin
      a = bus.rs_addr[k*AW +: AW];
      if (bus.rs_used[k] && a != 0 && m_busy[a] && !(bus.wb_en && bus.wb_addr == a))
        stall = 1;
    end
    if (bus.issue_wr_en && bus.issue_rd != 0 && m_busy[bus.issue_rd] &&
        !((bus.wb_en || bus.wb_clr) && bus.wb_addr == bus.issue_rd))
      stall = 1;
    return !stall;
  endfunction

  function automatic bit exp_fire();
    return bus.issue_valid && exp_ready() && !bus.flush;
  endfunction

  // Model state advance at each rising edge.
  always @(posedge clk) begin
    bit f;
    f = exp_fire();
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) m_reg[i] = 64'd0;
      m_busy = 32'd0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) m_reg[bus.wb_addr] = bus.wb_data;
      if ((bus.wb_en || bus.wb_clr) && bus.wb_addr != 0) m_busy[bus.wb_addr] = 1'b0;
      if (f && bus.issue_wr_en && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
  end

  // Compare DUT against model mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("issue_ready", {63'd0, bus.issue_ready}, {63'd0, exp_ready()});
      chk("issue_fire", {63'd0, bus.issue_fire}, {63'd0, exp_fire()});
      chk("busy_vec", {32'd0, bus.busy_vec}, {32'd0, m_busy});
      for (int k = 0; k < NRD; k++)
        chk($sformatf("rs_data%0d", k), bus.rs_data[k*XLEN +: XLEN], exp_rd(k));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs_addr     = '0;
    bus.rs_used     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_wr_en = 1'b0;
    bus.issue_rd    = '0;
    bus.flush       = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.wb_clr      = 1'b0;
  endtask

  task automatic issue_wr(input logic [AW-1:0] rd);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_wr_en = 1'b1;
    bus.issue_rd    = rd;
  endtask

  initial begin
    int cand [NREGS];
    int n;
    int p;
    n_checks = 0;
    n_fail   = 0;
    check_en = 1'b0;
    reset    = 1'b0;
    idle();
    tick();
    tick();
    reset    = 1'b1;
    check_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_busy", {32'd0, bus.busy_vec}, 64'd0);
    chk("rst_ready", {63'd0, bus.issue_ready}, 64'd1);

    // 1: write x5, read it back; x0 ignores writes
    tick(); issue_wr(5);
    tick(); idle(); bus.wb_en = 1'b1; bus.wb_addr = 5; bus.wb_data = 64'h1234;
    tick(); idle(); bus.rs_addr[AW-1:0] = 5; bus.rs_used = 2'b01;
    @(negedge clk);
    chk("t1_x5", bus.rs_data[XLEN-1:0], 64'h1234);
    chk("t1_busy", {32'd0, bus.busy_vec}, 64'd0);
    tick(); idle(); bus.wb_en = 1'b1; bus.wb_addr = 0; bus.wb_data = 64'hFF;
    tick(); idle(); bus.rs_used = 2'b11;
    @(negedge clk);
    chk("t1_x0", bus.rs_data[XLEN-1:0], 64'd0);

    // 2: RAW stall on x7 released by same-cycle writeback
    tick(); issue_wr(7);
    tick(); idle(); bus.issue_valid = 1'b1; bus.rs_used = 2'b01; bus.rs_addr[AW-1:0] = 7;
    @(negedge clk);
    chk("t2_stall", {63'd0, bus.issue_ready}, 64'd0);
    chk("t2_busy7", {63'd0, bus.busy_vec[7]}, 64'd1);
    tick();
    @(negedge clk);
    chk("t2_stall_hold", {63'd0, bus.issue_ready}, 64'd0);
    tick(); bus.wb_en = 1'b1; bus.wb_addr = 7; bus.wb_data = 64'hABCD;
    @(negedge clk);
    chk("t2_ready", {63'd0, bus.issue_ready}, 64'd1);
    chk("t2_bypass", bus.rs_data[XLEN-1:0], 64'hABCD);
    tick(); idle();
    @(negedge clk);
    chk("t2_busy7_clr", {63'd0, bus.busy_vec[7]}, 64'd0);

    // 3: WAW on x9; clear in same cycle lets it issue and set wins
    tick(); issue_wr(9);
    tick(); issue_wr(9);
    @(negedge clk);
    chk("t3_waw", {63'd0, bus.issue_ready}, 64'd0);
    tick(); issue_wr(9); bus.wb_clr = 1'b1; bus.wb_addr = 9;
    @(negedge clk);
    chk("t3_ready", {63'd0, bus.issue_ready}, 64'd1);
    tick(); idle();
    @(negedge clk);
    chk("t3_busy9", {63'd0, bus.busy_vec[9]}, 64'd1);
    tick(); idle(); bus.wb_clr = 1'b1; bus.wb_addr = 9;

    // 4: unused port does not stall
    tick(); issue_wr(3);
    tick(); idle(); bus.issue_valid = 1'b1; bus.rs_addr = {5'd3, 5'd0}; bus.rs_used = 2'b01;
    @(negedge clk);
    chk("t4_unused", {63'd0, bus.issue_ready}, 64'd1);
    tick(); bus.rs_used = 2'b10;
    @(negedge clk);
    chk("t4_used", {63'd0, bus.issue_ready}, 64'd0);
    tick(); idle(); bus.wb_clr = 1'b1; bus.wb_addr = 3;

    // 5: flush blocks the claim, writeback still lands
    tick(); issue_wr(2);
    tick(); issue_wr(4); bus.flush = 1'b1; bus.wb_en = 1'b1; bus.wb_addr = 2; bus.wb_data = 64'h55;
    @(negedge clk);
    chk("t5_fire", {63'd0, bus.issue_fire}, 64'd0);
    tick(); idle(); bus.rs_addr[AW-1:0] = 2; bus.rs_used = 2'b01;
    @(negedge clk);
    chk("t5_busy4", {63'd0, bus.busy_vec[4]}, 64'd0);
    chk("t5_x2", bus.rs_data[XLEN-1:0], 64'h55);

    // 6: reset mid-hazard clears everything
    tick(); issue_wr(10);
    tick(); issue_wr(11); reset = 1'b0; bus.wb_en = 1'b1; bus.wb_addr = 10; bus.wb_data = 64'h99;
    tick(); idle(); reset = 1'b1; bus.issue_valid = 1'b1; bus.rs_addr = {5'd10, 5'd5}; bus.rs_used = 2'b11;
    @(negedge clk);
    chk("t6_busy", {32'd0, bus.busy_vec}, 64'd0);
    chk("t6_rd", bus.rs_data, 128'd0);
    chk("t6_ready", {63'd0, bus.issue_ready}, 64'd1);

    // randomized traffic on a small register window to provoke hazards
    repeat (3000) begin
      tick();
      idle();
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      for (int k = 0; k < NRD; k++) bus.rs_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      bus.rs_used     = 2'($urandom_range(0, 3));
      bus.issue_valid = ($urandom_range(0, 3) != 0);
      bus.issue_wr_en = 1'($urandom_range(0, 1));
      bus.issue_rd    = AW'($urandom_range(0, 7));
      bus.flush       = ($urandom_range(0, 7) == 0);
      n = 0;
      for (int i = 1; i < NREGS; i++) if (m_busy[i]) begin cand[n] = i; n++; end
      p = int'($urandom_range(0, 3));
      bus.wb_data = {$urandom, $urandom};
      if (p == 3) begin
        bus.wb_en = 1'b1; bus.wb_addr = '0;
      end else if (p != 0 && n > 0) begin
        bus.wb_addr = AW'(cand[$urandom_range(0, n - 1)]);
        if (p == 1) bus.wb_en = 1'b1; else bus.wb_clr = 1'b1;
      end
    end
    tick();
    idle();
    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_id_regfile_sb.md
Name: pipeline_id_regfile_sb

Overview:
- Parametrised register file for the decode stage.
- Configurable data width, register count and number of read ports.
- Write-through bypass from the writeback port.
- Per-register busy scoreboard that stalls decode on RAW and WAW hazards.
- Sits between instruction decode and the ID/EX pipeline register. Receives writeback from the WB stage and drives `issue_ready` back to IF/ID.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥2); register 0 is hardwired zero.
- NRD, 2, number of read ports (1..4).
- AW, $clog2(NREGS), register address width (localparam, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-low reset.
- rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rs_used  in  NRD  bit k=1: the current instruction actually reads port k; only used ports participate in hazard checks.
- rs_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- issue_valid  in  1  decode holds a valid instruction.
- issue_wr_en  in  1  the instruction writes a destination register.
- issue_rd  in  AW  destination register.
- flush  in  1  squash the decode-slot instruction this cycle.
- issue_ready  out  1  instruction may advance this cycle.
- issue_fire  out  1  issue_valid & issue_ready & ~flush.
- wb_en  in  1  writeback: write wb_data into wb_addr and release its busy bit.
- wb_addr  in  AW  writeback register.
- wb_data  in  XLEN  writeback data.
- wb_clr  in  1  release the busy bit of wb_addr without writing (squashed producer).
- busy_vec  out  NREGS  current scoreboard, bit i = register i busy.

Behaviour:
- Reset (reset=0 at a rising edge):
  - All registers become 0.
  - busy_vec becomes 0.
  - Reset overrides any simultaneous wb_en, wb_clr or issue_fire.
  - Reset mid-hazard therefore releases any stall on the next cycle.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Its busy bit is never set; busy_vec[0] is constant 0.
- Reads are combinational, zero latency. For port k:
  - if rs_addr_k==0: output 0;
  - else if wb_en and wb_addr==rs_addr_k: output wb_data (write-through bypass);
  - else: output the stored register value.
- Write: on a rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
- Scoreboard next-state for register i≠0, in priority order:
  - set if issue_fire & issue_wr_en & issue_rd==i;
  - else clear if (wb_en|wb_clr) & wb_addr==i;
  - else hold.
  - Set beats clear when both hit the same register in one cycle; the new producer owns the bit.
- Hazard check for read port k (raw_k):
  - raw_k = rs_used[k] & rs_addr_k!=0 & busy[rs_addr_k] & ~(wb_en & wb_addr==rs_addr_k).
  - The bypassed value is correct, so a same-cycle wb_en releases the RAW stall.
  - wb_clr does NOT release the RAW stall in that cycle, because no data is supplied.
- Hazard check for the destination (waw):
  - waw = issue_wr_en & issue_rd!=0 & busy[issue_rd] & ~((wb_en|wb_clr) & wb_addr==issue_rd).
- issue_ready = ~(OR of raw_k) & ~waw.
  - Depends only on current inputs and busy state; it does not depend on issue_valid, so no combinational loop.
- Flush:
  - issue_fire=0, so no busy bit is set that cycle.
  - Writeback and clear still take effect.
  - busy_vec is not otherwise changed; squashed in-flight producers must each present wb_clr.
- Illegal: wb_en and wb_clr both high. The implementation treats it as wb_en.
- Required assertions:
  - wb_en or wb_clr to a non-busy register i≠0.
  - issue_fire with issue_wr_en to a busy register.

Test Plan:
1. Reset, then write x5=0x1234 via wb_en; next cycle rs_addr0=5 → rs_data0=0x1234, busy_vec=0. Write x0=0xFF → reads of x0 return 0.
2. Issue with issue_wr_en=1, rd=7 (busy_vec[7]→1); next instruction rs_used=01, rs_addr0=7 → issue_ready=0. Stall holds until a cycle with wb_en, wb_addr=7, wb_data=0xABCD: that same cycle issue_ready=1, rs_data0=0xABCD; busy_vec[7]=0 after the edge.
3. rd=9 busy; issue with rd=9 → issue_ready=0 (WAW). Same cycle as wb_clr to 9 → issue_ready=1. After the edge busy_vec[9]=1 (set wins).
4. rd=3 busy; rs_addr1=3 with rs_used=01 → issue_ready=1 (unused port ignored). With rs_used=10 → issue_ready=0.
5. flush=1 with issue_valid=1, rd=4 → issue_fire=0 and busy_vec[4] stays 0. A concurrent wb_en to x2=0x55 still writes.
6. Busy x10 plus pending write data present, assert reset=0 for one edge → all registers read 0, busy_vec=0, issue_ready=1 next cycle.
